tt_reg_bridge: RTL
==================

# tt_reg_bridge

Parametrised register bridge exposing `NUM_REGS` internal registers of `DATA_W` bits through the fixed 8-bit TinyTapeout pin set (`ui_in`, `uo_out`, `uio_*`). It sits directly under the `tt_um_*` top and is driven byte-wise by the cocotb bench or an external host. User logic consumes the `reg_q` outputs and supplies `reg_d` status values. It generalises the fixed 8-bit pin harness to arbitrary register width and count, with framed read/write and error reporting.

## Interface
- `DATA_W`, 16: register width; multiple of 8, range 8..32; `BYTES` = `DATA_W`/8.
- `NUM_REGS`, 4: number of registers, 1..16.
- `clk` in 1: single clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `ena` in 1: design selected; when 0, state and all outputs freeze and no bytes are accepted.
- `ui_in` in 8: `[7]` valid, `[6]` rnw, `[5]` clear-error, `[4]` abort, `[3:0]` addr. Address fields are sampled only on command bytes.
- `uio_in` in 8: write data byte.
- `uio_out` out 8: read data byte.
- `uio_oe` out 8: 8'hFF in `RDATA`, else 8'h00.
- `uo_out` out 8: `[0]` busy (state ≠ `IDLE`), `[1]` sticky error, `[2]` done pulse, `[3]` 0, `[7:4]` byte index within frame.
- `reg_q` out `NUM_REGS*DATA_W`: register contents; reg i occupies `[i*DATA_W +: DATA_W]`.
- `reg_d` in `NUM_REGS*DATA_W`: read-back sources, same packing.
- `reg_wr` out `NUM_REGS`: one-cycle write-commit strobe per register.

## Operation
- A byte is accepted on any rising `clk` edge with `ena`=1 and `ui_in[7]`=1. Inputs are synchronous; no synchroniser.
- States: `IDLE`, `WDATA`, `WCOMMIT`, `RDATA`.
- `IDLE`, byte accepted:
  - `[5]`=1: clear error and stay in `IDLE`. `[5]` takes priority over `[6]`.
  - `[6]`=0: go to `WDATA` with index=0.
  - `[6]`=1: snapshot `reg_d[addr]` into the shift register, then go to `RDATA` with index=0.
- `WDATA`: each accepted byte shifts `uio_in` in, LSB byte first, and increments index. After the `BYTES`-th byte, go to `WCOMMIT`.
- `WCOMMIT`, one cycle, does not need valid:
  - `reg_q[addr]` is loaded and `reg_wr[addr]`=1.
  - done=1.
  - Return to `IDLE`.
- `RDATA`:
  - `uio_out` = byte[index] of the snapshot.
  - Each accepted byte advances index.
  - After the `BYTES`-th accept: done pulse and return to `IDLE`.
- Address ≥ `NUM_REGS`:
  - Frame still runs to completion.
  - Writes are discarded and no `reg_wr` is raised.
  - Reads return 0.
  - Error is set at command accept and stays set until a clear-error command or reset.
- Abort (`ui_in[4]`=1 on any accepted byte outside `IDLE`): return to `IDLE` next cycle. No commit, no done, and no `reg_d` snapshot is kept.
- Reset values: `reg_q`=0, `reg_wr`=0, `uo_out`=0, `uio_out`=0, `uio_oe`=0, state `IDLE`, index 0, error 0.

## Timing
- Write latency: `reg_q` updates on the edge one cycle after the last data byte is accepted.
- Read: `uio_out`/`uio_oe` are valid from the cycle after the command is accepted. Each byte is held until the accept that consumes it.
- The done pulse lasts exactly one cycle.
- Back-to-back frames: a new command is accepted in the first `IDLE` cycle after done, so there is a minimum of 1 idle cycle after a write.
- `ena` falling mid-frame pauses the frame. The index and snapshot are preserved, and the frame resumes when `ena` returns high.
- `rst_n` asserted mid-frame: all outputs return to reset values immediately (asynchronous). A partial write never commits.

## Structure
- Package `tt_reg_bridge_pkg`:
  - State enum.
  - Bit-position constants for `ui_in` fields and `uo_out` flags.
  - A `MAX_BYTES` constant.
- Sub-module `tt_reg_bridge_shreg`:
  - `BYTES`×8 shift/select register with parallel load (read snapshot), byte shift-in (write) and byte select out.
  - Same `clk`/`rst_n`.

## Test plan
- Write reg 2 (`DATA_W`=16): bytes 0x82, 0x34, 0x12. Required: `reg_q[2]`=0x1234 one cycle after the last byte, `reg_wr`=4'b0100 for one cycle, done pulse.
- Read reg 1 with `reg_d[1]`=0xBEEF: command 0xC1. Required: `uio_oe`=0xFF, `uio_out`=0xEF, then 0xBE after one accept. Returns to `IDLE` after the second accept and `uio_oe` goes back to 0.
- Out-of-range write to addr 7 with `NUM_REGS`=4:
  - Required: frame completes, no `reg_wr`, `uo_out[1]`=1.
  - Then command 0xA0: `uo_out[1]`=0 and state stays `IDLE`.
- Abort after the first write data byte (second byte 0x90): `reg_q` unchanged, busy=0 next cycle, no done pulse.
- Reset mid-frame and `ena` gating:
  - `rst_n` low during `WDATA`: all outputs 0 immediately, `reg_q`=0.
  - Separately, `ena`=0 for 3 cycles mid-read: `uio_out` and index hold.
  - After `ena` returns, the frame completes normally.

Source files
------------

// File: rtl/tt_reg_bridge_pkg.sv
// Shared types and field positions for the byte-wide register bridge.
package tt_reg_bridge_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_WCOMMIT, ST_RDATA} state_e;

  localparam int UI_VALID = 7;
  localparam int UI_RNW   = 6;
  localparam int UI_CLR   = 5;
  localparam int UI_ABORT = 4;

  localparam int UO_BUSY  = 0;
  localparam int UO_ERR   = 1;
  localparam int UO_DONE  = 2;

  localparam int MAX_BYTES = 4;
endpackage

// File: rtl/tt_reg_bridge_shreg.sv
// Frame data holder: parallel load for read snapshots, LSB-first byte shift-in
// for writes, byte select for the read port.
module tt_reg_bridge_shreg #(
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [BYTES*8-1:0] load_data,
  input  logic               shift,
  input  logic [7:0]         din,
  input  logic [3:0]         sel,
  output logic [BYTES*8-1:0] q,
  output logic [7:0]         dout
);
  logic [BYTES*8-1:0] data, shifted;

  // New byte enters at the top so the first byte ends up in the LSBs.
  generate
    if (BYTES == 1) begin : g_one
      assign shifted = din;
    end else begin : g_many
      assign shifted = {din, data[BYTES*8-1:8]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data <= '0;
    else if (clr)   data <= '0;
    else if (load)  data <= load_data;
    else if (shift) data <= shifted;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < BYTES; i++)
      if (sel == 4'(i)) dout = data[i*8 +: 8];
  end

  assign q = data;
endmodule

// File: rtl/tt_reg_bridge.sv
// Framed byte-wide read/write access to NUM_REGS registers of DATA_W bits
// over the TinyTapeout pin set.
module tt_reg_bridge
  import tt_reg_bridge_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [7:0]                 ui_in,
  input  logic [7:0]                 uio_in,
  output logic [7:0]                 uio_out,
  output logic [7:0]                 uio_oe,
  output logic [7:0]                 uo_out,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  input  logic [NUM_REGS*DATA_W-1:0] reg_d,
  output logic [NUM_REGS-1:0]        reg_wr
);
  localparam int BYTES = DATA_W / 8;

  state_e state, state_nxt;
  logic [3:0] idx, addr;
  logic       err, done;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0] snap, sh_q;
  logic [7:0] sh_byte;
  logic acc, abort, last, cmd_oor;

  assign acc     = ena & ui_in[UI_VALID];
  assign abort   = acc & ui_in[UI_ABORT] & (state != ST_IDLE);
  assign last    = (idx == 4'(BYTES-1));
  assign cmd_oor = (32'(ui_in[3:0]) >= NUM_REGS);

  // Out-of-range addresses match no entry, so reads snapshot zero.
  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ui_in[3:0] == 4'(i)) snap = reg_d[i*DATA_W +: DATA_W];
  end

  tt_reg_bridge_shreg #(.BYTES(BYTES)) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .load      (acc & (state == ST_IDLE) & ~ui_in[UI_CLR] & ui_in[UI_RNW]),
    .load_data (snap),
    .shift     (acc & (state == ST_WDATA) & ~ui_in[UI_ABORT]),
    .din       (uio_in),
    .sel       (idx),
    .q         (sh_q),
    .dout      (sh_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (acc && !ui_in[UI_CLR]) state_nxt = ui_in[UI_RNW] ? ST_RDATA : ST_WDATA;
      ST_WDATA:   if (abort) state_nxt = ST_IDLE;
                  else if (acc && last) state_nxt = ST_WCOMMIT;
      ST_WCOMMIT: if (ena) state_nxt = ST_IDLE;
      ST_RDATA:   if (abort || (acc && last)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    uio_oe  = '0;
    uio_out = '0;
    if (state == ST_RDATA) begin
      uio_oe  = 8'hFF;
      uio_out = sh_byte;
    end
    uo_out = {idx, 1'b0, done, err, state != ST_IDLE};
  end

  // Everything, including the strobes, holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0; addr <= '0; err <= 1'b0; done <= 1'b0;
      regs <= '0; reg_wr <= '0;
    end else if (ena) begin
      done   <= 1'b0;
      reg_wr <= '0;
      case (state)
        ST_IDLE: if (acc) begin
          if (ui_in[UI_CLR]) err <= 1'b0;
          else begin
            addr <= ui_in[3:0];
            idx  <= '0;
            if (cmd_oor) err <= 1'b1;
          end
        end
        ST_WDATA:
          if (abort)    idx <= '0;
          else if (acc) idx <= idx + 4'd1;
        ST_WCOMMIT: begin
          idx <= '0;
          if (!abort) begin
            done <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++)
              if (addr == 4'(i)) begin
                regs[i]   <= sh_q;
                reg_wr[i] <= 1'b1;
              end
          end
        end
        ST_RDATA:
          if (abort) idx <= '0;
          else if (acc) begin
            if (last) begin
              idx  <= '0;
              done <= 1'b1;
            end else idx <= idx + 4'd1;
          end
        default: idx <= '0;
      endcase
    end
  end

  assign reg_q = regs;
endmodule
